// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer front end: T1..T6 ring counter, registered opcode decode, halt.
// Optional single-step gating via RUN/STEP when SAP_1_SINGLE_STEP_EN is defined.
module sap_1_controller_sequencer (
  input  logic       CLK,
  input  logic       CLRbar,
`ifdef SAP_1_SINGLE_STEP_EN
  input  logic       RUN,
  input  logic       STEP,
`endif
  input  logic [3:0] opcode,
  output logic [6:1] ring_counter,
  output logic       LDA,
  output logic       ADD,
  output logic       SUB,
  output logic       OUT,
  output logic       HLT,
  output logic       halted,
  output logic       clk_enable
);

  typedef enum logic [2:0] {
    DEC_NOP,
    DEC_LDA,
    DEC_ADD,
    DEC_SUB,
    DEC_OUT,
    DEC_HLT
  } decode_t;

  localparam logic [6:1] T1 = 6'b000001;
  localparam logic [6:1] T3 = 6'b000100;

  logic [6:1] ring_q;
  logic [6:1] ring_d;
  decode_t    decode_q;
  decode_t    decode_d;
  logic       halted_q;
  logic       halted_d;
  logic       advance;
  logic       ring_is_onehot;

  assign ring_is_onehot = (ring_q != 6'b000000) && ((ring_q & (ring_q - 6'b000001)) == 6'b000000);

`ifdef SAP_1_SINGLE_STEP_EN
  logic step_sync1;
  logic step_sync2;
  logic step_prev;
  logic step_pulse;

  // A synchronized STEP rising edge grants exactly one advance; halt still wins.
  assign step_pulse = step_sync2 & ~step_prev;
  assign advance    = ~halted_q & (RUN | step_pulse);

  always_ff @(negedge CLK or negedge CLRbar) begin
    if (!CLRbar) begin
      step_sync1 <= 1'b0;
      step_sync2 <= 1'b0;
      step_prev  <= 1'b0;
    end else begin
      step_sync1 <= STEP;
      step_sync2 <= step_sync1;
      step_prev  <= step_sync2;
    end
  end
`else
  assign advance = ~halted_q;
`endif

  always_ff @(negedge CLK or negedge CLRbar) begin
    if (!CLRbar) begin
      ring_q   <= T1;
      decode_q <= DEC_NOP;
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      decode_q <= decode_d;
      halted_q <= halted_d;
    end
  end

  // Opcode is captured only on the T3->T4 advance; a corrupt ring recovers to T1.
  always_comb begin
    ring_d   = ring_q;
    decode_d = decode_q;
    halted_d = halted_q;
    if (advance) begin
      if (ring_is_onehot) begin
        ring_d = {ring_q[5:1], ring_q[6]};
      end else begin
        ring_d = T1;
      end
      if (ring_q == T3) begin
        case (opcode)
          4'b0000: decode_d = DEC_LDA;
          4'b0001: decode_d = DEC_ADD;
          4'b0010: decode_d = DEC_SUB;
          4'b1110: decode_d = DEC_OUT;
          4'b1111: decode_d = DEC_HLT;
          default: decode_d = DEC_NOP;
        endcase
        halted_d = (opcode == 4'b1111);
      end
    end
  end

  always_comb begin
    LDA = 1'b0;
    ADD = 1'b0;
    SUB = 1'b0;
    OUT = 1'b0;
    HLT = 1'b0;
    case (decode_q)
      DEC_LDA: LDA = 1'b1;
      DEC_ADD: ADD = 1'b1;
      DEC_SUB: SUB = 1'b1;
      DEC_OUT: OUT = 1'b1;
      DEC_HLT: HLT = 1'b1;
      default: ;
    endcase
    ring_counter = ring_q;
    halted       = halted_q;
    clk_enable   = ~halted_q;
  end

endmodule
